// File: rtl/bus_master_arbiter.sv
// Round-robin 68000 bus-arbitration master for N DMA requesters; owns br_n/bgack_n.
// Optional hold-time limit with forced release when ARB_TIMEOUT_EN is defined.
module bus_master_arbiter #(
  parameter int unsigned N        = 2,
  parameter int unsigned HOLD_MAX = 1024
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 phi2,
  input  logic [N-1:0]                         req,
  output logic [N-1:0]                         grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner,
  output logic                                 busy,
  output logic                                 br_n,
  input  logic                                 bg_n,
  output logic                                 bgack_n,
  input  logic                                 as_n,
  input  logic                                 dtack_n,
  output logic                                 timeout
);

  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_WAIT_BUS = 3'd2;
  localparam logic [2:0] S_OWN      = 3'd3;
  localparam logic [2:0] S_REL      = 3'd4;

  if (N < 2 || N > 8 || HOLD_MAX < 1) begin : g_param_check
    $error("bus_master_arbiter: N must be 2..8 and HOLD_MAX at least 1");
  end

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] next_ptr;
  logic [OW-1:0] pick;
  logic [OW-1:0] scan;
  logic          found;
  logic [N-1:0]  req_eff;
  logic [N-1:0]  owner_onehot;
  logic          force_rel;
  logic          release_own;

  assign owner_onehot = N'(1) << owner;
  assign release_own  = !req[owner] || force_rel;
  assign next_ptr     = (owner == OW'(N - 1)) ? '0 : owner + 1'b1;

  // Winner is the first eligible request at or above rr_ptr, wrapping modulo N.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    scan  = rr_ptr;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req_eff[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
      scan = (scan == OW'(N - 1)) ? '0 : scan + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (found) state_nxt = S_REQ;
      S_REQ:      if (!bg_n) state_nxt = S_WAIT_BUS;
      S_WAIT_BUS: if (as_n && dtack_n) state_nxt = S_OWN;
      S_OWN:      if (release_own) state_nxt = S_REL;
      S_REL:      state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Once br_n is low the handshake always runs through OWN/REL, even if the
  // requester has gone away, so the CPU sees bgack_n before br_n is withdrawn.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      br_n    <= 1'b1;
      bgack_n <= 1'b1;
      grant   <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      busy    <= 1'b0;
    end else if (phi2) begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (found) begin
            owner <= pick;
            br_n  <= 1'b0;
          end
        end
        S_WAIT_BUS: begin
          if (as_n && dtack_n) begin
            bgack_n <= 1'b0;
            br_n    <= 1'b1;
            grant   <= req[owner] ? owner_onehot : '0;
          end
        end
        S_OWN: begin
          if (release_own) begin
            grant   <= '0;
            bgack_n <= 1'b1;
          end
        end
        S_REL: begin
          rr_ptr <= next_ptr;
        end
        S_REQ: begin
        end
        default: begin
          br_n    <= 1'b1;
          bgack_n <= 1'b1;
          grant   <= '0;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(HOLD_MAX + 1);

  logic [CW-1:0] hold_cnt;
  logic [N-1:0]  mask;

  assign force_rel = (state == S_OWN) && req[owner] && (hold_cnt == CW'(HOLD_MAX - 1));
  assign req_eff   = req & ~mask;

  // A timed-out requester stays masked until its req is seen low on a phi2 tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      mask     <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (phi2) begin
        hold_cnt <= (state == S_OWN) ? hold_cnt + 1'b1 : '0;
        mask     <= (mask & req) | (force_rel ? owner_onehot : '0);
        if (force_rel) timeout <= 1'b1;
      end
    end
  end
`else
  assign force_rel = 1'b0;
  assign req_eff   = req;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed self-checking bench for bus_master_arbiter (N=2, HOLD_MAX=8).
module tb_bus_master_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       phi2;
  logic [1:0] req;
  logic [1:0] grant;
  logic [0:0] owner;
  logic       busy;
  logic       br_n;
  logic       bg_n;
  logic       bgack_n;
  logic       as_n;
  logic       dtack_n;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_master_arbiter #(.N(2), .HOLD_MAX(8)) dut (
    .clk(clk), .reset_n(reset_n), .phi2(phi2), .req(req), .grant(grant),
    .owner(owner), .busy(busy), .br_n(br_n), .bg_n(bg_n), .bgack_n(bgack_n),
    .as_n(as_n), .dtack_n(dtack_n), .timeout(timeout)
  );

  // One phi2 tick: a dead clk edge with phi2=0, then an active edge; sample #1 after it.
  task automatic tick();
    @(negedge clk); phi2 = 1'b0;
    @(negedge clk); phi2 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; phi2 = 1'b0; req = 2'b00;
    bg_n = 1'b1; as_n = 1'b1; dtack_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (br_n !== 1'b1)     begin n_err++; $display("FAIL reset_br_n got %b want 1", br_n); end
    n_cmp++; if (bgack_n !== 1'b1)  begin n_err++; $display("FAIL reset_bgack_n got %b want 1", bgack_n); end
    n_cmp++; if (grant !== 2'b00)   begin n_err++; $display("FAIL reset_grant got %b want 00", grant); end
    n_cmp++; if (owner !== 1'b0)    begin n_err++; $display("FAIL reset_owner got %b want 0", owner); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (timeout !== 1'b0)  begin n_err++; $display("FAIL reset_timeout got %b want 0", timeout); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_single_grant();
    req = 2'b01;
    tick();
    n_cmp++; if (br_n !== 1'b0)    begin n_err++; $display("FAIL single_br_low got %b want 0", br_n); end
    n_cmp++; if (busy !== 1'b1)    begin n_err++; $display("FAIL single_busy got %b want 1", busy); end
    tick();
    n_cmp++; if (br_n !== 1'b0)    begin n_err++; $display("FAIL single_br_hold got %b want 0", br_n); end
    bg_n = 1'b0;
    tick();
    n_cmp++; if (bgack_n !== 1'b1) begin n_err++; $display("FAIL single_bgack_early got %b want 1", bgack_n); end
    tick();
    n_cmp++; if (bgack_n !== 1'b0) begin n_err++; $display("FAIL single_bgack got %b want 0", bgack_n); end
    n_cmp++; if (grant !== 2'b01)  begin n_err++; $display("FAIL single_grant got %b want 01", grant); end
    n_cmp++; if (br_n !== 1'b1)    begin n_err++; $display("FAIL single_br_release got %b want 1", br_n); end
    bg_n = 1'b1;
    tick();
    n_cmp++; if (grant !== 2'b01)  begin n_err++; $display("FAIL single_grant_hold got %b want 01", grant); end
    req = 2'b00;
    tick();
    n_cmp++; if (grant !== 2'b00)  begin n_err++; $display("FAIL single_drop_grant got %b want 00", grant); end
    n_cmp++; if (bgack_n !== 1'b1) begin n_err++; $display("FAIL single_drop_bgack got %b want 1", bgack_n); end
    n_cmp++; if (busy !== 1'b1)    begin n_err++; $display("FAIL single_rel_busy got %b want 1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL single_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic       exp_owner;
    logic [1:0] exp_grant;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_owner = (k % 2 == 0) ? 1'b1 : 1'b0;
      exp_grant = exp_owner ? 2'b10 : 2'b01;
      tick();
      n_cmp++; if (owner !== exp_owner) begin n_err++; $display("FAIL rr_owner[%0d] got %b want %b", k, owner, exp_owner); end
      bg_n = 1'b0;
      tick();
      n_cmp++; if (grant !== 2'b00)     begin n_err++; $display("FAIL rr_wait_grant[%0d] got %b want 00", k, grant); end
      tick();
      n_cmp++; if (grant !== exp_grant) begin n_err++; $display("FAIL rr_grant[%0d] got %b want %b", k, grant, exp_grant); end
      n_cmp++; if (bgack_n !== 1'b0)    begin n_err++; $display("FAIL rr_bgack[%0d] got %b want 0", k, bgack_n); end
      bg_n = 1'b1;
      tick();
      n_cmp++; if (grant !== exp_grant) begin n_err++; $display("FAIL rr_grant_hold[%0d] got %b want %b", k, grant, exp_grant); end
      req = ~exp_grant;
      tick();
      n_cmp++; if (grant !== 2'b00)     begin n_err++; $display("FAIL rr_rel_grant[%0d] got %b want 00", k, grant); end
      n_cmp++; if (bgack_n !== 1'b1)    begin n_err++; $display("FAIL rr_rel_bgack[%0d] got %b want 1", k, bgack_n); end
      req = 2'b11;
      tick();
      n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rr_gap_busy[%0d] got %b want 0", k, busy); end
    end
  endtask

  task automatic test_bus_hold();
    req = 2'b10; as_n = 1'b0;
    tick();
    n_cmp++; if (owner !== 1'b1)   begin n_err++; $display("FAIL hold_owner got %b want 1", owner); end
    bg_n = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bgack_n !== 1'b1) begin n_err++; $display("FAIL hold_as_bgack[%0d] got %b want 1", i, bgack_n); end
      n_cmp++; if (grant !== 2'b00)  begin n_err++; $display("FAIL hold_as_grant[%0d] got %b want 00", i, grant); end
    end
    as_n = 1'b1; dtack_n = 1'b0;
    tick();
    n_cmp++; if (bgack_n !== 1'b1) begin n_err++; $display("FAIL hold_dtack_bgack got %b want 1", bgack_n); end
    dtack_n = 1'b1;
    tick();
    n_cmp++; if (bgack_n !== 1'b0) begin n_err++; $display("FAIL hold_bgack got %b want 0", bgack_n); end
    n_cmp++; if (grant !== 2'b10)  begin n_err++; $display("FAIL hold_grant got %b want 10", grant); end
    bg_n = 1'b1; req = 2'b00;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL hold_end_busy got %b want 0", busy); end
  endtask

  task automatic test_short_pulse();
    req = 2'b01;
    tick();
    n_cmp++; if (br_n !== 1'b0)    begin n_err++; $display("FAIL pulse_br got %b want 0", br_n); end
    n_cmp++; if (owner !== 1'b0)   begin n_err++; $display("FAIL pulse_owner got %b want 0", owner); end
    req = 2'b00; bg_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (bgack_n !== 1'b0) begin n_err++; $display("FAIL pulse_bgack got %b want 0", bgack_n); end
    n_cmp++; if (grant !== 2'b00)  begin n_err++; $display("FAIL pulse_grant got %b want 00", grant); end
    bg_n = 1'b1;
    tick();
    n_cmp++; if (bgack_n !== 1'b1) begin n_err++; $display("FAIL pulse_bgack_one got %b want 1", bgack_n); end
    n_cmp++; if (grant !== 2'b00)  begin n_err++; $display("FAIL pulse_grant_rel got %b want 00", grant); end
    tick();
    n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL pulse_idle got %b want 0", busy); end
    req = 2'b11;
    tick();
    n_cmp++; if (owner !== 1'b1)   begin n_err++; $display("FAIL pulse_ptr_owner got %b want 1", owner); end
  endtask

  // Continues from the REQ state with owner 1 left by test_short_pulse.
  task automatic test_async_reset();
    bg_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (grant !== 2'b10)  begin n_err++; $display("FAIL areset_pre_grant got %b want 10", grant); end
    bg_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (grant !== 2'b00)  begin n_err++; $display("FAIL areset_grant got %b want 00", grant); end
    n_cmp++; if (bgack_n !== 1'b1) begin n_err++; $display("FAIL areset_bgack got %b want 1", bgack_n); end
    n_cmp++; if (br_n !== 1'b1)    begin n_err++; $display("FAIL areset_br got %b want 1", br_n); end
    n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL areset_busy got %b want 0", busy); end
    req = 2'b00;
    @(negedge clk); reset_n = 1'b1;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    req = 2'b01;
    tick();
    bg_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (grant !== 2'b01)   begin n_err++; $display("FAIL to_grant got %b want 01", grant); end
    bg_n = 1'b1;
    repeat (7) tick();
    n_cmp++; if (bgack_n !== 1'b0)  begin n_err++; $display("FAIL to_bgack_7 got %b want 0", bgack_n); end
    n_cmp++; if (timeout !== 1'b0)  begin n_err++; $display("FAIL to_early got %b want 0", timeout); end
    tick();
    n_cmp++; if (timeout !== 1'b1)  begin n_err++; $display("FAIL to_pulse got %b want 1", timeout); end
    n_cmp++; if (grant !== 2'b00)   begin n_err++; $display("FAIL to_grant_rel got %b want 00", grant); end
    n_cmp++; if (bgack_n !== 1'b1)  begin n_err++; $display("FAIL to_bgack_rel got %b want 1", bgack_n); end
    @(negedge clk); phi2 = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (timeout !== 1'b0)  begin n_err++; $display("FAIL to_pulse_width got %b want 0", timeout); end
    n_cmp++; if (busy !== 1'b1)     begin n_err++; $display("FAIL to_phi2_gate got %b want 1", busy); end
    tick();
    tick();
    n_cmp++; if (br_n !== 1'b1)     begin n_err++; $display("FAIL to_masked_br got %b want 1", br_n); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL to_masked_busy got %b want 0", busy); end
    req = 2'b00;
    tick();
    req = 2'b01;
    tick();
    n_cmp++; if (br_n !== 1'b0)     begin n_err++; $display("FAIL to_rereq_br got %b want 0", br_n); end
    bg_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (grant !== 2'b01)   begin n_err++; $display("FAIL to_regrant got %b want 01", grant); end
    bg_n = 1'b1; req = 2'b00;
    tick(); tick();
  endtask
`else
  task automatic test_unbounded_hold();
    req = 2'b01;
    tick();
    bg_n = 1'b0;
    tick();
    tick();
    bg_n = 1'b1;
    repeat (12) tick();
    n_cmp++; if (bgack_n !== 1'b0)  begin n_err++; $display("FAIL nohold_bgack got %b want 0", bgack_n); end
    n_cmp++; if (grant !== 2'b01)   begin n_err++; $display("FAIL nohold_grant got %b want 01", grant); end
    n_cmp++; if (timeout !== 1'b0)  begin n_err++; $display("FAIL nohold_timeout got %b want 0", timeout); end
    req = 2'b00;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL nohold_end_busy got %b want 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_bus_hold();
    test_short_pulse();
    test_async_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_unbounded_hold();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
- Shares the 68000-compatible CPU bus between N DMA-capable requesters (floppy/SCSI/video DMA engines).
- Drives the CPU wrapper's br_n/bgack_n pins and observes bg_n and the bus-cycle strobes.
- Grants the bus to one requester at a time in round-robin order, and only after the CPU has handed the bus over cleanly.
- Sits between the CPU wrapper and the per-device DMA controllers; it owns all 68000 bus-arbitration signalling.

Parameters:
- N, 2, number of requesters (2..8).
- HOLD_MAX, 1024, maximum phi2 ticks one requester may own the bus. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- phi2  in  1  CPU bus-phase enable. All state changes occur only on clk edges with phi2=1.
- req  in  N  per-requester bus request, level, active high.
- grant  out  N  one-hot bus grant, level.
- owner  out  max(1,clog2(N))  index of current or pending winner.
- busy  out  1  arbiter state is not IDLE.
- br_n  out  1  bus request to CPU.
- bg_n  in  1  bus grant from CPU.
- bgack_n  out  1  bus grant acknowledge to CPU.
- as_n  in  1  CPU address strobe.
- dtack_n  in  1  bus data acknowledge.
- timeout  out  1  one-clk pulse when an owner is forcibly released.

Behaviour:
- Reset values (asynchronous): state=IDLE, br_n=1, bgack_n=1, grant=0, owner=0, rr pointer=0, timeout=0, busy=0. Reset mid-ownership drops grant and bgack_n on the same edge.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT_BUS, OWN, REL. The FSM evaluates only on phi2 ticks.
- IDLE:
  - If any req bit is high, pick the winner: the first set bit scanning upward from the rr pointer, wrapping modulo N.
  - Latch owner, set br_n=0, go to REQ.
  - If no req bit is high, stay in IDLE.
- REQ: hold br_n=0. When sampled bg_n=0, go to WAIT_BUS.
- WAIT_BUS: when as_n=1 and dtack_n=1 on the same tick:
  - set bgack_n=0 and br_n=1;
  - set grant[owner]=1, unless req[owner] is already low;
  - go to OWN.
- OWN:
  - bgack_n stays 0.
  - When sampled req[owner]=0, go to REL, setting grant=0 and bgack_n=1 on that edge.
- REL: set rr pointer=(owner+1) mod N, then go to IDLE on the next tick. The bus is therefore released for at least one phi2 tick between owners.
- Commitment rule: once br_n has been driven low, the sequence always completes through OWN/REL. br_n is never withdrawn before bgack_n, because the CPU keeps its grant latched until it sees bgack released.
  - If req[owner] drops during REQ or WAIT_BUS, grant is never raised. OWN exits on its first tick; bgack_n is low for exactly one tick.
- Other requests arriving during REQ..REL are queued and do not change owner.
- grant is zero whenever bgack_n=1.
- busy = (state != IDLE).
- Latency: from a req rise with an idle bus to br_n low is 1 phi2 tick.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in OWN, cleared on entry to OWN and incremented each phi2 tick.
  - When the count reaches HOLD_MAX, the arbiter forces REL: grant=0, bgack_n=1, timeout pulses for 1 clk.
  - The offending requester is masked from arbitration until its req is sampled low.
- Without the macro: no counter is built, timeout is tied to 0, and ownership is unbounded.

Test Plan:
- N=2. req=01, CPU returns bg_n=0 two ticks after br_n falls, as_n=1 -> br_n low 1 tick after req; bgack_n=0 and grant=01 one tick after bg_n=0 is seen. req drops -> grant=00 and bgack_n=1 on the same edge; busy=0 two ticks later.
- Set req=11 held continuously -> grants alternate 01,10,01,10. Each grant is separated by at least one tick with bgack_n=1 and grant=00.
- bg_n=0 while as_n=0 for 3 ticks -> bgack_n stays 1 and grant=00 until as_n=1 and dtack_n=1, then assert on the next tick.
- req[0] pulses for 1 tick only -> br_n/bg_n handshake still completes; bgack_n low exactly 1 tick; grant never asserted; pointer advances to 1.
- Assert reset_n=0 asynchronously while in OWN with grant=10 -> grant=00, bgack_n=1, br_n=1 immediately, without waiting for a clk edge.
- ARB_TIMEOUT_EN, HOLD_MAX=8, req=01 held -> forced release after 8 OWN ticks with a timeout pulse. Requester 0 gets no further grant until req[0]=0 is seen, then it may re-request.
